// File: rtl/mstq_arbiter_pkg.sv
// Shared constants and types for the master-FIFO packet arbiter.
package mstq_arbiter_pkg;

    localparam int unsigned W         = 18;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned START_BIT = W - 1;
    localparam int unsigned END_BIT   = W - 2;

    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    function automatic logic is_start(input logic [W-1:0] word);
        return word[START_BIT];
    endfunction

    function automatic logic is_end(input logic [W-1:0] word);
        return word[END_BIT];
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin chooser: on a tie the port that was not served last wins.
module rr_pick2 (
    input  logic [1:0] i_cand,
    input  logic       i_last,
    output logic       o_win,
    output logic       o_any
);

    assign o_win = (i_cand == 2'b11) ? ~i_last : i_cand[1];
    assign o_any = |i_cand;

endmodule

// File: rtl/mstq_arbiter.sv
// Packet arbiter sharing the bus-master command FIFO between two receivers.
// Grant is held from start word to end word; zero-latency pass-through datapath.
module mstq_arbiter
    import mstq_arbiter_pkg::*;
(
    input  logic             clk_125,
    input  logic             sys_rst_n,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_data,
    output logic             req1_ready,
    output logic [W-1:0]     mst_din,
    output logic             mst_wr_en,
    input  logic             mst_full,
    input  logic [1:0]       port_en,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic [CNT_W-1:0] drop_cnt0,
    output logic [CNT_W-1:0] drop_cnt1,
    output logic             proto_err,
    input  logic             err_clr
);

    state_e           r_state;
    logic             r_owner;
    logic             r_last;
    logic             r_drop_mode;
    logic             r_proto_err;
    logic [CNT_W-1:0] r_pkt_cnt0;
    logic [CNT_W-1:0] r_pkt_cnt1;
    logic [CNT_W-1:0] r_drop_cnt0;
    logic [CNT_W-1:0] r_drop_cnt1;

    logic [1:0]   w_valid;
    logic [1:0]   w_start;
    logic [1:0]   w_cand;
    logic [1:0]   w_bad;
    logic [1:0]   w_ready;
    logic         w_busy;
    logic         w_win;
    logic         w_any;
    logic         w_sel;
    logic [W-1:0] w_sel_data;
    logic         w_sel_valid;
    logic         w_drop;
    logic         w_fwd_ok;
    logic         w_accept;
    logic         w_done;
    logic         w_err_set;

    assign w_valid = {req1_valid, req0_valid};
    assign w_start = {is_start(req1_data), is_start(req0_data)};
    assign w_busy  = (r_state == StBusy);

    // In IDLE, words without a start bit are strays: swallowed per port, never granted.
    assign w_cand = w_busy ? 2'b00 : (w_valid & w_start);
    assign w_bad  = w_busy ? 2'b00 : (w_valid & ~w_start);

    rr_pick2 u_pick (
        .i_cand (w_cand),
        .i_last (r_last),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    assign w_sel       = w_busy ? r_owner : w_win;
    assign w_sel_data  = w_sel ? req1_data : req0_data;
    assign w_sel_valid = w_busy ? w_valid[w_sel] : w_any;
    // Enable is only looked at on the start word; drop_mode carries it through the sequence.
    assign w_drop      = w_busy ? r_drop_mode : ~port_en[w_win];
    assign w_fwd_ok    = w_drop | ~mst_full;
    assign w_accept    = w_sel_valid & w_fwd_ok;
    assign w_done      = w_accept & is_end(w_sel_data);
    assign w_err_set   = (|w_bad) | (w_busy & w_accept & is_start(w_sel_data));

    // Ready per port: stray consumption plus the granted port's forwarding ready.
    always_comb begin
        w_ready = w_bad;
        if (w_busy || w_any) begin
            w_ready[w_sel] = w_ready[w_sel] | w_fwd_ok;
        end
        if (!sys_rst_n) begin
            w_ready = 2'b00;
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign mst_din    = w_sel_data;
    assign mst_wr_en  = w_accept & ~w_drop & sys_rst_n;

    assign pkt_cnt0  = r_pkt_cnt0;
    assign pkt_cnt1  = r_pkt_cnt1;
    assign drop_cnt0 = r_drop_cnt0;
    assign drop_cnt1 = r_drop_cnt1;
    assign proto_err = r_proto_err;

    // Grant FSM, statistics counters and sticky error flag.
    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= StIdle;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_drop_mode <= 1'b0;
            r_proto_err <= 1'b0;
            r_pkt_cnt0  <= '0;
            r_pkt_cnt1  <= '0;
            r_drop_cnt0 <= '0;
            r_drop_cnt1 <= '0;
        end else begin
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end else if (err_clr) begin
                r_proto_err <= 1'b0;
            end

            if (w_done) begin
                unique case ({w_drop, w_sel})
                    2'b00: r_pkt_cnt0  <= r_pkt_cnt0 + CNT_INC;
                    2'b01: r_pkt_cnt1  <= r_pkt_cnt1 + CNT_INC;
                    2'b10: r_drop_cnt0 <= r_drop_cnt0 + CNT_INC;
                    2'b11: r_drop_cnt1 <= r_drop_cnt1 + CNT_INC;
                endcase
            end

            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        if (!is_end(w_sel_data)) begin
                            r_state     <= StBusy;
                            r_drop_mode <= w_drop;
                        end
                    end
                end
                StBusy: begin
                    if (w_done) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mstq_arbiter.md
# mstq_arbiter

Packet-level arbiter that shares the single bus-master command FIFO (18-bit words, read by the PCIe TLP engine) between the PHY1 and PHY2 receivers. Each receiver pushes complete TLP command sequences over a valid/ready port. The arbiter grants one port at a time and holds the grant from a start word to its end word, so sequences are never interleaved. Ports are served round-robin at packet boundaries. It also provides per-port enables, packet/drop counters and a sticky protocol-error flag for the PCI register block.

## Interface
- W, 18, command word width; bit W-1 = start-of-sequence, bit W-2 = end-of-sequence, rest payload
- CNT_W, 16, width of statistics counters (wrap-around)

- clk_125  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- req0_valid / req1_valid  in  1  port has a word
- req0_data / req1_data  in  W  command word
- req0_ready / req1_ready  out  1  word accepted this cycle when valid&ready
- mst_din  out  W  word to master FIFO
- mst_wr_en  out  1  FIFO write strobe
- mst_full  in  1  FIFO full
- port_en  in  2  per-port enable, sampled at sequence start
- pkt_cnt0 / pkt_cnt1  out  CNT_W  sequences forwarded (counted on end word)
- drop_cnt0 / drop_cnt1  out  CNT_W  sequences dropped (disabled port)
- proto_err  out  1  sticky protocol error
- err_clr  in  1  clears proto_err

## Operation
- States: IDLE, BUSY. Registers: state, owner (0/1), last (last served port), drop_mode.
- IDLE: a candidate is a port with valid and start bit set. If one port is a candidate, it wins. If both are, the port != last wins.
- IDLE, winner enabled: word passes through when ~mst_full. Set owner=winner and last=winner.
  - Word also has end bit: stay IDLE and increment pkt_cnt[winner].
  - Otherwise: go to BUSY with drop_mode=0.
- IDLE, winner disabled: word is consumed with ready=1 and not written.
  - Word has end bit: stay IDLE and increment drop_cnt[winner].
  - Otherwise: go to BUSY with drop_mode=1.
- IDLE, valid word without start bit: consume it, discard it, set proto_err. Evaluated per port; the loser's word waits.
- BUSY: only owner is served. ready[owner] = drop_mode | ~mst_full; the other port's ready=0.
  - An accepted word with end bit returns to IDLE and increments pkt_cnt or drop_cnt (by drop_mode).
  - A start bit inside BUSY sets proto_err; the word is treated as payload (forwarded or dropped).
- port_en changes during a sequence take effect at the next start.
- mst_din = selected req data; mst_wr_en = valid & ready & ~drop & grant. Combinational pass-through, no buffering.
- Counters wrap from 2^CNT_W-1 to 0.
- proto_err: set has priority over err_clr in the same cycle.

## Timing
- Zero-latency datapath: a word accepted in cycle n is written to the FIFO in cycle n.
- Back-pressure: mst_full=1 forces ready=0 on the forwarding path. The requester must hold data stable until accepted.
- A single-word sequence completes in 1 cycle. An N-word sequence occupies N accepted cycles, with no bubble between consecutive sequences.
- Counters, state and proto_err update on the clock edge after the accepting cycle.
- Reset (async, any time, including mid-sequence): state=IDLE, last=1 (port 0 wins first tie), owner=0, drop_mode=0. All counters 0, proto_err=0, all readies 0, mst_wr_en=0. A partially forwarded sequence is not completed; the receivers are reset by the same signal.

## Structure
- Shared package: W, start/end bit indices, state encoding (IDLE=0, BUSY=1).
- One sub-module, rr_pick2: a 2-input round-robin chooser (cand[1:0], last → win, any). It is reusable for the TX slot scheduler.

## Test plan
- Port 0 sends a 3-word sequence (0x2_0001, 0x0_0002, 0x1_0003) while port 1 is idle → FIFO receives exactly these 3 words in 3 cycles; pkt_cnt0=1.
- Both ports offer a start word in the same cycle after reset → port 0 sequence written fully first, then port 1; next tie goes to port 0 again only after port 1 is served.
- mst_full asserted for 4 cycles mid-sequence → ready=0, no writes, data held; sequence resumes with no lost or duplicated word.
- port_en=2'b10 with port 0 sending a 2-word sequence → no FIFO writes; drop_cnt0=1; port 1 is still served.
- Port 1 sends 0x0_00AA in IDLE → word consumed, proto_err=1; err_clr pulse → proto_err=0.
- sys_rst_n low during BUSY → all outputs at reset values immediately; the next start from port 1 is granted normally.
